btn_latch_arbiter: RTL and testbench
====================================

# btn_latch_arbiter

Arbitrating controller for the two-button set/reset LED latch. It synchronises and debounces the active-low buttons BUT1 and BUT2, turns each debounced press into a request for ownership of the shared latch output, and grants ownership round-robin with a minimum hold time. It drives LED1/LED2 as the latch Q/QN pair and sits directly behind the board pins, clocked from the 100 MHz CLK, with its own internal tick prescaler.

## Interface

Parameters:
- DIV_W, 12: tick prescaler width; tick period is 2^DIV_W CLK cycles (≈24.4 kHz at 100 MHz). Must be ≥1.
- DEB_CNT, 4: consecutive ticks of a stable differing sample needed to accept a button change. Must be ≥1.
- HOLD_TICKS, 8: minimum ownership duration in ticks. Must be ≥1.

Ports:
- CLK  input  1  system clock, all logic on posedge.
- RSTN  input  1  asynchronous, active-low reset.
- BUT1  input  1  button 1, active-low, asynchronous to CLK.
- BUT2  input  1  button 2, active-low, asynchronous to CLK.
- LED1  output  1  latch Q; 1 while requester 1 owns.
- LED2  output  1  latch QN; 1 while requester 2 owns.
- GNT  output  2  one-hot owner (bit0 = requester 1, bit1 = requester 2), 00 = no owner.
- TICK  output  1  one-cycle prescaler strobe.

## Operation

- Reset (RSTN=0, takes effect immediately): LED1=0, LED2=0, GNT=00, TICK=0, prescaler=0, synchroniser and debounced states=1 (released), debounce counters=0, pending flags=0, hold counter=0, state=IDLE, last-served=2.
- Prescaler: free-running DIV_W-bit up-counter that wraps. TICK=1 for the single cycle in which the counter is all-ones.
- Synchroniser: two flops per button.
- Debounce: evaluated only on TICK, per button.
  - If the synced sample equals the debounced state, clear the counter.
  - Otherwise increment the counter. When it reaches DEB_CNT, the debounced state takes the sample and the counter clears.
  - A debounced 1→0 transition produces a one-cycle press event (EV1/EV2). Releases produce no event.
- Pending flags P1/P2:
  - Set on the matching press event.
  - Cleared on the cycle that grants that requester.
  - A press event from the current owner is discarded and never sets its flag.
- FSM:
  - IDLE: no owner. If P1|EV1 or P2|EV2, grant and go to HOLD. If both requesters are eligible, grant the one not equal to last-served; after reset this is requester 1.
  - HOLD: the hold counter is loaded with HOLD_TICKS on grant and decrements on each TICK. At 0, go to FREE. Events from the non-owner set its pending flag.
  - FREE: the owner is retained and the LEDs are unchanged. If the non-owner has P|EV, grant it, update last-served, and go to HOLD. Otherwise stay.
- Grant: updates last-served. Owner 1 gives LED1=1, LED2=0, GNT=01. Owner 2 gives LED1=0, LED2=1, GNT=10. LED1 and LED2 are never both 1. Outputs are registered.

## Timing

- Pin to synced value: 2 cycles.
- Synced change to press event: DEB_CNT ticks, i.e. between (DEB_CNT−1)·2^DIV_W+1 and DEB_CNT·2^DIV_W cycles.
- Press event to GNT/LED update: 1 cycle (event in cycle n, outputs change after edge n+1) when state is IDLE or FREE.
- Hold length: between (HOLD_TICKS−1)·2^DIV_W+1 and HOLD_TICKS·2^DIV_W cycles from grant.
- HOLD→FREE: 1 cycle. A pending switch is granted on the next cycle, so expiry to new grant is 2 cycles.
- Simultaneous events in IDLE: the round-robin winner is granted in the same cycle; the loser stays pending and is granted automatically after hold expiry.
- Event arriving in the same cycle that FREE evaluates: considered in that evaluation.
- Counter widths: debounce $clog2(DEB_CNT+1), hold $clog2(HOLD_TICKS+1). No overflow is possible.
- RSTN asserted mid-HOLD: all outputs return to reset values without waiting for CLK. The pending request is lost.

## Test plan

Run with DIV_W=2, DEB_CNT=2, HOLD_TICKS=3. TICK occurs every 4 cycles.

1. Assert RSTN=0 with buttons released → LED1=0, LED2=0, GNT=00, TICK=0. After release, TICK pulses every 4th cycle.
2. Hold BUT1=0 for 20 cycles → GNT=01, LED1=1, LED2=0 within 12 cycles of BUT1 falling. No further change when BUT1 is released.
3. Pulse BUT2=0 for 3 cycles while requester 1 owns → GNT stays 01 and no pending flag is set.
4. From reset, drive BUT1 and BUT2 to 0 in the same cycle → GNT=01 first. Within 2+12 cycles of hold expiry, GNT=10, LED1=0, LED2=1.
5. Press BUT1 again while requester 1 owns in FREE → GNT stays 01 permanently. A later BUT2 press → GNT=10 one cycle after its event.
6. Drive RSTN=0 mid-HOLD with BUT2 pending → outputs are 0/0/00 immediately. After release with both buttons held, requester 1 wins first.

Source files
------------

// File: rtl/btn_latch_arbiter.sv
// Two-button set/reset latch controller: synchronises and debounces BUT1/BUT2,
// then hands ownership of the LED pair round-robin with a minimum hold time.
module btn_latch_arbiter #(
  parameter int unsigned DIV_W      = 12,
  parameter int unsigned DEB_CNT    = 4,
  parameter int unsigned HOLD_TICKS = 8
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       BUT1,
  input  logic       BUT2,
  output logic       LED1,
  output logic       LED2,
  output logic [1:0] GNT,
  output logic       TICK
);

  localparam int unsigned DEB_W  = $clog2(DEB_CNT + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FREE = 2'd2
  } state_t;

  logic [DIV_W-1:0]           div_q;
  logic                       tick_c;
  logic [1:0]                 sync1_q;
  logic [1:0]                 sync2_q;
  logic [1:0]                 deb_q;
  logic [1:0][DEB_W-1:0]      deb_cnt_q;
  logic [1:0]                 ev_q;
  logic [1:0]                 pend_q;
  logic [1:0]                 elig_c;
  logic [HOLD_W-1:0]          hold_q;
  logic                       last_q;
  logic [1:0]                 gnt_q;
  logic [1:0]                 gnt_c;
  logic [1:0]                 grant_c;
  state_t                     state_q;
  state_t                     state_d;

  // Free-running prescaler; the strobe is the all-ones count.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) div_q <= '0;
    else       div_q <= div_q + DIV_W'(1);
  end

  assign tick_c = &div_q;
  assign TICK   = tick_c;

  // Two-flop synchroniser, bit0 = BUT1, bit1 = BUT2; released level is 1.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {BUT2, BUT1};
      sync2_q <= sync1_q;
    end
  end

  // Tick-sampled debounce; a press event fires when the accepted level falls.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      deb_q     <= 2'b11;
      deb_cnt_q <= '0;
      ev_q      <= '0;
    end else begin
      ev_q <= '0;
      if (tick_c) begin
        for (int i = 0; i < 2; i++) begin
          if (sync2_q[i] == deb_q[i]) begin
            deb_cnt_q[i] <= '0;
          end else if (deb_cnt_q[i] == DEB_W'(DEB_CNT - 1)) begin
            deb_q[i]     <= sync2_q[i];
            deb_cnt_q[i] <= '0;
            ev_q[i]      <= deb_q[i];
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
          end
        end
      end
    end
  end

  assign elig_c = pend_q | ev_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Arbitration: on a tie in IDLE the requester not served last wins.
  always_comb begin
    state_d = state_q;
    grant_c = '0;
    unique case (state_q)
      IDLE: begin
        if (&elig_c) grant_c = last_q ? 2'b01 : 2'b10;
        else         grant_c = elig_c;
        if (|elig_c) state_d = HOLD;
      end
      HOLD: begin
        if (hold_q == '0) state_d = FREE;
      end
      FREE: begin
        if (|(elig_c & ~gnt_q)) begin
          grant_c = ~gnt_q;
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_c = gnt_q;
    if (|grant_c) gnt_c = grant_c;
  end

  // Owner, LEDs, pending flags, round-robin pointer and hold timer.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      gnt_q  <= '0;
      LED1   <= 1'b0;
      LED2   <= 1'b0;
      pend_q <= '0;
      last_q <= 1'b1;
      hold_q <= '0;
    end else begin
      gnt_q  <= gnt_c;
      LED1   <= gnt_c[0];
      LED2   <= gnt_c[1];
      pend_q <= (pend_q | (ev_q & ~gnt_q)) & ~grant_c;
      if (|grant_c) begin
        last_q <= grant_c[1];
        hold_q <= HOLD_W'(HOLD_TICKS);
      end else if (state_q == HOLD && tick_c && hold_q != '0) begin
        hold_q <= hold_q - HOLD_W'(1);
      end
    end
  end

  assign GNT = gnt_q;

endmodule

// File: tb/tb_btn_latch_arbiter.sv
// Bench for btn_latch_arbiter: directed vector table, corner sequences and
// random button activity checked every cycle against a behavioural model.
module tb_btn_latch_arbiter;

  localparam int DIV_W      = 2;
  localparam int DEB_CNT    = 2;
  localparam int HOLD_TICKS = 3;
  localparam int PER        = 1 << DIV_W;

  logic       CLK  = 1'b0;
  logic       RSTN = 1'b1;
  logic       but1 = 1'b1;
  logic       but2 = 1'b1;
  logic       LED1;
  logic       LED2;
  logic [1:0] GNT;
  logic       TICK;

  int n_checks = 0;
  int n_fail   = 0;

  btn_latch_arbiter #(
    .DIV_W      (DIV_W),
    .DEB_CNT    (DEB_CNT),
    .HOLD_TICKS (HOLD_TICKS)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .BUT1 (but1),
    .BUT2 (but2),
    .LED1 (LED1),
    .LED2 (LED2),
    .GNT  (GNT),
    .TICK (TICK)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: requester index 0/1, owner -1 when nobody owns.
  int m_cycle;
  bit m_s1    [2];
  bit m_s2    [2];
  bit m_deb   [2];
  bit m_ev    [2];
  bit m_pend  [2];
  int m_stable[2];
  int m_owner;
  int m_last;
  int m_hold_left;
  bit m_holding;

  task automatic model_reset();
    m_cycle = 0;
    for (int r = 0; r < 2; r++) begin
      m_s1[r] = 1'b1;  m_s2[r] = 1'b1;  m_deb[r] = 1'b1;
      m_ev[r] = 1'b0;  m_pend[r] = 1'b0; m_stable[r] = 0;
    end
    m_owner = -1;
    m_last = 1;
    m_hold_left = 0;
    m_holding = 1'b0;
  endtask

  task automatic model_step();
    bit tk;
    bit want [2];
    bit lvl  [2];
    bit pins [2];
    int winner;
    tk = ((m_cycle % PER) == PER - 1);
    m_cycle = m_cycle + 1;
    for (int r = 0; r < 2; r++) want[r] = m_pend[r] | m_ev[r];
    winner = -1;
    if (m_owner < 0) begin
      if (want[0] && want[1]) winner = 1 - m_last;
      else if (want[0])       winner = 0;
      else if (want[1])       winner = 1;
    end else if (!m_holding && want[1 - m_owner]) begin
      winner = 1 - m_owner;
    end
    for (int r = 0; r < 2; r++) begin
      if (m_ev[r] && r != m_owner) m_pend[r] = 1'b1;
      if (r == winner) m_pend[r] = 1'b0;
    end
    if (winner >= 0) begin
      m_owner = winner;
      m_last = winner;
      m_holding = 1'b1;
      m_hold_left = HOLD_TICKS;
    end else if (m_holding) begin
      if (m_hold_left == 0) m_holding = 1'b0;
      else if (tk) m_hold_left = m_hold_left - 1;
    end
    pins[0] = but1;
    pins[1] = but2;
    for (int r = 0; r < 2; r++) begin
      lvl[r] = m_deb[r];
      if (tk) begin
        if (m_s2[r] == m_deb[r]) begin
          m_stable[r] = 0;
        end else begin
          m_stable[r] = m_stable[r] + 1;
          if (m_stable[r] >= DEB_CNT) begin
            lvl[r] = m_s2[r];
            m_stable[r] = 0;
          end
        end
      end
      m_ev[r]  = m_deb[r] && !lvl[r];
      m_deb[r] = lvl[r];
      m_s2[r]  = m_s1[r];
      m_s1[r]  = pins[r];
    end
  endtask

  function automatic logic [4:0] model_out();
    logic o0, o1, tk;
    o0 = (m_owner == 0);
    o1 = (m_owner == 1);
    tk = ((m_cycle % PER) == PER - 1);
    return {o0, o1, o1, o0, tk};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare against the model mid-cycle, then advance one clock.
  task automatic step_cycle();
    @(negedge CLK);
    check("model", 8'({LED1, LED2, GNT, TICK}), 8'(model_out()));
    @(posedge CLK);
    if (RSTN) model_step();
    else      model_reset();
    #2;
  endtask

  task automatic apply_reset();
    RSTN = 1'b0;
    model_reset();
    repeat (3) step_cycle();
    RSTN = 1'b1;
  endtask

  task automatic wait_gnt(input logic [1:0] target, input int budget, input string name);
    int n;
    n = 0;
    while (GNT !== target && n < budget) begin
      step_cycle();
      n++;
    end
    check(name, 8'(GNT), 8'(target));
  endtask

  typedef struct {
    logic       b1;
    logic       b2;
    int         cycles;
    logic [1:0] gnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int ticks;
    int run1;
    int run2;

    vecs[0] = '{1'b1, 1'b1, 10, 2'b00};
    vecs[1] = '{1'b0, 1'b1, 20, 2'b01};
    vecs[2] = '{1'b1, 1'b1, 20, 2'b01};
    vecs[3] = '{1'b1, 1'b0,  3, 2'b01};
    vecs[4] = '{1'b1, 1'b1, 20, 2'b01};
    vecs[5] = '{1'b0, 1'b1, 20, 2'b01};
    vecs[6] = '{1'b1, 1'b1, 20, 2'b01};
    vecs[7] = '{1'b1, 1'b0, 24, 2'b10};
    vecs[8] = '{1'b1, 1'b1, 30, 2'b10};
    vecs[9] = '{1'b0, 1'b1, 30, 2'b01};

    #1 RSTN = 1'b0;
    model_reset();
    #1 check("reset_state", 8'({LED1, LED2, GNT, TICK}), 8'h00);
    repeat (2) step_cycle();
    RSTN = 1'b1;

    ticks = 0;
    for (int c = 0; c < 16; c++) begin
      step_cycle();
      if (TICK) ticks++;
    end
    check("tick_count", 8'(ticks), 8'd4);

    for (int v = 0; v < 10; v++) begin
      but1 = vecs[v].b1;
      but2 = vecs[v].b2;
      repeat (vecs[v].cycles) step_cycle();
      check($sformatf("vec%0d_gnt", v), 8'(GNT), 8'(vecs[v].gnt));
      check($sformatf("vec%0d_led", v), 8'({LED2, LED1}), 8'(vecs[v].gnt));
    end

    // Simultaneous presses straight out of reset.
    but1 = 1'b1; but2 = 1'b1;
    apply_reset();
    but1 = 1'b0; but2 = 1'b0;
    wait_gnt(2'b01, 20, "tie_first");
    wait_gnt(2'b10, 30, "tie_second");
    check("tie_led", 8'({LED1, LED2}), 8'b01);

    // Reset in the middle of a hold with requester 2 pending.
    but1 = 1'b1; but2 = 1'b1;
    apply_reset();
    but1 = 1'b0; but2 = 1'b0;
    wait_gnt(2'b01, 20, "pre_rst_grant");
    repeat (2) step_cycle();
    RSTN = 1'b0;
    model_reset();
    #1 check("async_rst", 8'({LED1, LED2, GNT, TICK}), 8'h00);
    repeat (2) step_cycle();
    RSTN = 1'b1;
    wait_gnt(2'b01, 20, "post_rst_grant");

    // Random button activity, including one asynchronous reset.
    but1 = 1'b1; but2 = 1'b1;
    apply_reset();
    run1 = int'($urandom_range(1, 40));
    run2 = int'($urandom_range(1, 40));
    for (int c = 0; c < 3000; c++) begin
      if (run1 == 0) begin
        but1 = ~but1;
        run1 = int'($urandom_range(1, 40));
      end
      if (run2 == 0) begin
        but2 = ~but2;
        run2 = int'($urandom_range(1, 40));
      end
      run1--;
      run2--;
      if (c == 1500) begin
        RSTN = 1'b0;
        model_reset();
      end
      if (c == 1503) RSTN = 1'b1;
      step_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
